// File: rtl/mig_native_bram_responder_if.sv
// MIG 7-series Native (UI) command, write-data and read-return signals.
// The user-side controller drives the master modport, the responder takes the slave one.
interface mig_native_bram_responder_if #(
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28
);
    logic [MIG_Addr_Port_Size-1:0]   app_addr;
    logic [2:0]                      app_cmd;
    logic                            app_en;
    logic                            app_rdy;
    logic [MIG_Data_Port_Size-1:0]   app_wdf_data;
    logic [MIG_Data_Port_Size/8-1:0] app_wdf_mask;
    logic                            app_wdf_wren;
    logic                            app_wdf_end;
    logic                            app_wdf_rdy;
    logic [MIG_Data_Port_Size-1:0]   app_rd_data;
    logic                            app_rd_data_valid;
    logic                            app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mig_native_bram_responder.sv
// BRAM-backed stand-in for the MIG 7-series UI: calibration delay, command and
// write-data queues, periodic refresh stalls and a fixed-latency in-order read return.
module mig_native_bram_responder #(
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28,
    parameter int Addr_Shift         = 3,
    parameter int Mem_Depth_Log2     = 10,
    parameter int Cmd_Fifo_Depth     = 4,
    parameter int Wdf_Fifo_Depth     = 4,
    parameter int Read_Latency       = 8,
    parameter int Calib_Delay        = 64,
    parameter int Stall_Period       = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    output logic                        init_calib,
    output logic                        protocol_error,
    mig_native_bram_responder_if.slave  app
);
    localparam int          DW  = MIG_Data_Port_Size;
    localparam int unsigned BW  = MIG_Data_Port_Size / 8;
    localparam int          IW  = Mem_Depth_Log2;
    localparam int          CAW = $clog2(Cmd_Fifo_Depth);
    localparam int          WAW = $clog2(Wdf_Fifo_Depth);
    localparam int          CLW = $clog2(Calib_Delay + 1);
    localparam int          STW = (Stall_Period > 1) ? $clog2(Stall_Period) : 1;
    localparam int unsigned RL1 = Read_Latency - 1;

    typedef enum logic {S_CALIB, S_RUN} calib_state_t;

    typedef struct packed {
        logic          rd;
        logic [IW-1:0] idx;
    } cmd_t;

    calib_state_t   calib_state;
    logic [CLW-1:0] calib_cnt;
    logic [STW-1:0] stall_cnt;
    logic           stall;

    cmd_t           cmd_mem [Cmd_Fifo_Depth];
    logic [CAW-1:0] cmd_wp, cmd_rp;
    logic [CAW:0]   cmd_cnt;
    cmd_t           cmd_in, cmd_head;
    logic           cmd_full, cmd_empty, cmd_ok, cmd_push, cmd_pop;

    logic [DW+BW-1:0] wdf_mem [Wdf_Fifo_Depth];
    logic [WAW-1:0]   wdf_wp, wdf_rp;
    logic [WAW:0]     wdf_cnt;
    logic [DW-1:0]    wdf_head_data;
    logic [BW-1:0]    wdf_head_mask;
    logic             wdf_full, wdf_empty, wdf_push, wdf_pop;

    logic             exec_rd, exec_wr;
    logic [DW-1:0]    mem [1 << IW];
    logic [DW-1:0]    rd_dat [Read_Latency-1];
    logic [Read_Latency-2:0] rd_vld;

    logic unused_addr_bits;
    assign unused_addr_bits = ^app.app_addr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            calib_state <= S_CALIB;
            calib_cnt   <= '0;
            init_calib  <= 1'b0;
        end else begin
            case (calib_state)
                S_CALIB: begin
                    if (calib_cnt == CLW'(Calib_Delay - 1)) begin
                        calib_state <= S_RUN;
                        init_calib  <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + CLW'(1);
                    end
                end
                default: init_calib <= 1'b1;
            endcase
        end
    end

    // Refresh emulation: one dead cycle each time the free-running counter wraps.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            stall_cnt <= '0;
        else if (stall_cnt == STW'(Stall_Period - 1))
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + STW'(1);
    end

    always_comb begin
        stall     = (Stall_Period != 0) && (stall_cnt == STW'(Stall_Period - 1));
        cmd_full  = (cmd_cnt == (CAW+1)'(Cmd_Fifo_Depth));
        cmd_empty = (cmd_cnt == '0);
        wdf_full  = (wdf_cnt == (WAW+1)'(Wdf_Fifo_Depth));
        wdf_empty = (wdf_cnt == '0);

        app.app_rdy     = init_calib & ~cmd_full & ~stall;
        app.app_wdf_rdy = init_calib & ~wdf_full;

        cmd_ok     = (app.app_cmd == 3'b000) || (app.app_cmd == 3'b001);
        cmd_in.rd  = app.app_cmd[0];
        cmd_in.idx = app.app_addr[Addr_Shift +: IW];
        cmd_push   = app.app_en & app.app_rdy & cmd_ok;
        wdf_push   = app.app_wdf_wren & app.app_wdf_rdy;

        cmd_head = cmd_mem[cmd_rp];
        {wdf_head_data, wdf_head_mask} = wdf_mem[wdf_rp];

        // A write at the head with no data yet blocks everything behind it.
        exec_rd = ~cmd_empty & cmd_head.rd;
        exec_wr = ~cmd_empty & ~cmd_head.rd & ~wdf_empty;
        cmd_pop = exec_rd | exec_wr;
        wdf_pop = exec_wr;
    end

    always_ff @(posedge aclk) begin
        if (cmd_push)
            cmd_mem[cmd_wp] <= cmd_in;
        if (wdf_push)
            wdf_mem[wdf_wp] <= {app.app_wdf_data, app.app_wdf_mask};
        if (exec_wr) begin
            for (int unsigned b = 0; b < BW; b++)
                if (!wdf_head_mask[b])
                    mem[cmd_head.idx][8*b +: 8] <= wdf_head_data[8*b +: 8];
        end
        if (exec_rd)
            rd_dat[0] <= mem[cmd_head.idx];
        for (int unsigned i = 1; i < RL1; i++)
            rd_dat[i] <= rd_dat[i-1];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_wp                <= '0;
            cmd_rp                <= '0;
            cmd_cnt               <= '0;
            wdf_wp                <= '0;
            wdf_rp                <= '0;
            wdf_cnt               <= '0;
            rd_vld                <= '0;
            app.app_rd_data       <= '0;
            app.app_rd_data_valid <= 1'b0;
            app.app_rd_data_end   <= 1'b0;
            protocol_error        <= 1'b0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CAW'(1);
            if (cmd_pop)  cmd_rp <= cmd_rp + CAW'(1);
            cmd_cnt <= cmd_cnt + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);

            if (wdf_push) wdf_wp <= wdf_wp + WAW'(1);
            if (wdf_pop)  wdf_rp <= wdf_rp + WAW'(1);
            wdf_cnt <= wdf_cnt + (WAW+1)'(wdf_push) - (WAW+1)'(wdf_pop);

            rd_vld[0] <= exec_rd;
            for (int unsigned i = 1; i < RL1; i++)
                rd_vld[i] <= rd_vld[i-1];

            app.app_rd_data_valid <= rd_vld[Read_Latency-2];
            app.app_rd_data_end   <= rd_vld[Read_Latency-2];
            if (rd_vld[Read_Latency-2])
                app.app_rd_data <= rd_dat[Read_Latency-2];

            if ((app.app_wdf_wren & ~app.app_wdf_end) | (app.app_en & app.app_rdy & ~cmd_ok))
                protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mig_native_bram_responder.sv
// Randomised scoreboard bench for mig_native_bram_responder against an in-order
// command/data pairing model of the UI memory.
module tb_mig_native_bram_responder;
    localparam int DW    = 128;
    localparam int AW    = 28;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int RL    = 8;
    localparam int CD    = 64;
    localparam int SP    = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic init_calib;
    logic perr;

    mig_native_bram_responder_if #(.MIG_Data_Port_Size(DW), .MIG_Addr_Port_Size(AW)) bus ();

    mig_native_bram_responder #(
        .MIG_Data_Port_Size(DW), .MIG_Addr_Port_Size(AW), .Addr_Shift(3),
        .Mem_Depth_Log2(10), .Cmd_Fifo_Depth(4), .Wdf_Fifo_Depth(4),
        .Read_Latency(RL), .Calib_Delay(CD), .Stall_Period(SP)
    ) dut (
        .aclk(clk), .aresetn(rstn), .init_calib(init_calib),
        .protocol_error(perr), .app(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { bit rd; int idx; } mcmd_t;
    mcmd_t         cmd_q[$];
    logic [DW-1:0] dat_q[$];
    logic [BW-1:0] msk_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            seen [DEPTH];
    int            wr_list[$];

    int            last_acc  = 0;
    int            vcnt      = 0;
    int            last_vcyc = 0;
    logic [DW-1:0] last_rd   = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    function automatic logic [AW-1:0] make_addr(input int idx);
        int hi, lo;
        hi = $urandom_range(0, 32767);
        lo = $urandom_range(0, 7);
        return AW'(hi * 8192 + idx * 8 + lo);
    endfunction

    // Commands retire strictly in order; a write retires once any data beat is available.
    function automatic void resolve();
        logic [DW-1:0] d;
        logic [BW-1:0] m;
        int            ix;
        while (cmd_q.size() > 0) begin
            ix = cmd_q[0].idx;
            if (cmd_q[0].rd) begin
                exp_q.push_back(ref_mem[ix]);
                void'(cmd_q.pop_front());
            end else if (dat_q.size() > 0) begin
                d = dat_q.pop_front();
                m = msk_q.pop_front();
                for (int b = 0; b < BW; b++)
                    if (!m[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
                void'(cmd_q.pop_front());
            end else begin
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rstn && bus.app_rd_data_valid) begin
            vcnt++;
            last_vcyc = cyc;
            last_rd   = bus.app_rd_data;
            check("rd_end", bus.app_rd_data_end, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no read data", bus.app_rd_data);
            end else begin
                check("rd_data", bus.app_rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, input int budget, output bit ok);
        int n = 0;
        bus.app_cmd  = c;
        bus.app_addr = a;
        bus.app_en   = 1'b1;
        while (!bus.app_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus.app_rdy;
        if (ok) begin
            last_acc = cyc + 1;
            if (c == 3'b000 || c == 3'b001) begin
                cmd_q.push_back('{rd: (c == 3'b001), idx: idx_of(a)});
                resolve();
            end
            @(negedge clk);
        end
        bus.app_en = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d, input logic [BW-1:0] m, input logic e,
                             input int budget, output bit ok);
        int n = 0;
        bus.app_wdf_data = d;
        bus.app_wdf_mask = m;
        bus.app_wdf_end  = e;
        bus.app_wdf_wren = 1'b1;
        while (!bus.app_wdf_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus.app_wdf_rdy;
        if (ok) begin
            dat_q.push_back(d);
            msk_q.push_back(m);
            resolve();
            @(negedge clk);
        end
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end  = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] m, input int mode);
        bit ok1, ok2;
        case (mode)
            0: fork
                   send_cmd(3'b000, a, 200, ok1);
                   send_data(d, m, 1'b1, 200, ok2);
               join
            1: begin send_data(d, m, 1'b1, 200, ok2); send_cmd(3'b000, a, 200, ok1); end
            default: begin send_cmd(3'b000, a, 200, ok1); send_data(d, m, 1'b1, 200, ok2); end
        endcase
        check("wr_accept", {ok1, ok2}, 2'b11);
        if (!seen[idx_of(a)]) begin
            seen[idx_of(a)] = 1'b1;
            wr_list.push_back(idx_of(a));
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit ok;
        send_cmd(3'b001, a, 200, ok);
        check("rd_accept", ok, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size() + cmd_q.size(), 0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            lows, v0, n, acc, r, idx;
        logic [DW-1:0] d;
        logic [BW-1:0] m;
        logic [DW-1:0] dh [5];
        logic [AW-1:0] ah [5];

        bus.app_addr     = '0;
        bus.app_cmd      = '0;
        bus.app_en       = 1'b0;
        bus.app_wdf_data = '0;
        bus.app_wdf_mask = '0;
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_init_calib", init_calib, 0);
        check("rst_app_rdy", bus.app_rdy, 0);
        check("rst_wdf_rdy", bus.app_wdf_rdy, 0);
        check("rst_rd_valid", bus.app_rd_data_valid, 0);
        check("rst_rd_end", bus.app_rd_data_end, 0);
        check("rst_rd_data", bus.app_rd_data, 0);
        check("rst_perr", perr, 0);

        rstn = 1'b1;
        for (int k = 1; k <= CD; k++) begin
            @(negedge clk);
            if (k == CD - 1) begin
                check("calib_early_init", init_calib, 0);
                check("calib_early_rdy", bus.app_rdy, 0);
                check("calib_early_wdf_rdy", bus.app_wdf_rdy, 0);
            end
        end
        check("calib_done", init_calib, 1);
        check("calib_wdf_rdy", bus.app_wdf_rdy, 1);
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            if (!bus.app_rdy) lows++;
            @(negedge clk);
        end
        check("calib_stall_window", lows, 1);

        // write then immediate read of 0x10
        do_write(28'h10, {16{8'hA5}}, '0, 0);
        do_read(28'h10);
        acc = last_acc;
        v0  = vcnt;
        n   = 0;
        while (vcnt == v0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("a5_latency", last_vcyc - acc, RL);
        check("a5_data", last_rd, {16{8'hA5}});
        @(negedge clk);
        #1;
        check("a5_single_pulse", bus.app_rd_data_valid, 0);
        check("a5_hold", bus.app_rd_data, {16{8'hA5}});

        do_write(28'h8, {16{8'h11}}, '0, 0);
        do_write(28'h8, {16{8'hFF}}, 16'h00FF, 0);
        do_read(28'h8);
        wait_drain();
        check("mask_merge", last_rd, {{8{8'hFF}}, {8{8'h11}}});

        // five commands with write data held off
        for (int k = 0; k < 5; k++) begin
            ah[k] = 28'h100 + 28'(k * 8);
            dh[k] = rand_word();
        end
        for (int k = 0; k < 4; k++) begin
            send_cmd(3'b000, ah[k], 200, ok);
            check("holdoff_accept", ok, 1);
        end
        send_cmd(3'b000, ah[4], 20, ok);
        check("holdoff_fifth_blocked", ok, 0);
        check("holdoff_rdy_low", bus.app_rdy, 0);
        fork
            begin
                bit ok5;
                send_cmd(3'b000, ah[4], 200, ok5);
                check("holdoff_fifth_accept", ok5, 1);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    bit okd;
                    send_data(dh[k], '0, 1'b1, 200, okd);
                    check("holdoff_data_accept", okd, 1);
                end
            end
        join
        for (int k = 0; k < 5; k++) begin
            seen[idx_of(ah[k])] = 1'b1;
            wr_list.push_back(idx_of(ah[k]));
        end
        for (int k = 0; k < 5; k++) do_read(ah[k]);
        wait_drain();
        check("holdoff_last", last_rd, dh[4]);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 3);
            if (r == 3 && wr_list.size() > 0) begin
                do_read(make_addr(wr_list[$urandom_range(0, wr_list.size() - 1)]));
            end else begin
                idx = $urandom_range(0, DEPTH - 1);
                d   = rand_word();
                m   = seen[idx] ? BW'($urandom) : '0;
                do_write(make_addr(idx), d, m, r % 3);
            end
        end
        wait_drain();

        lows = 0;
        for (int k = 0; k < 64; k++) begin
            bus.app_cmd  = 3'b001;
            bus.app_addr = make_addr(wr_list[$urandom_range(0, wr_list.size() - 1)]);
            bus.app_en   = 1'b1;
            if (bus.app_rdy) begin
                cmd_q.push_back('{rd: 1'b1, idx: idx_of(bus.app_addr)});
                resolve();
            end else begin
                lows++;
            end
            @(negedge clk);
        end
        bus.app_en = 1'b0;
        check("stall_low_count", lows, 4);
        wait_drain();

        v0 = vcnt;
        send_cmd(3'b010, 28'h10, 200, ok);
        repeat (20) @(negedge clk);
        check("perr_bad_cmd", perr, 1);
        check("bad_cmd_no_data", vcnt - v0, 0);

        for (int k = 0; k < 3; k++) do_read(make_addr(wr_list[k]));
        v0 = vcnt;
        rstn = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        dat_q.delete();
        msk_q.delete();
        #1;
        check("midrst_valid", bus.app_rd_data_valid, 0);
        check("midrst_perr", perr, 0);
        check("midrst_init", init_calib, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (!init_calib && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("recal_done", init_calib, 1);
        check("midrst_no_valid", vcnt - v0, 0);
        for (int k = 0; k < 4; k++) do_read(make_addr(wr_list[$urandom_range(0, wr_list.size() - 1)]));
        wait_drain();

        d = rand_word();
        send_data(d, '0, 1'b0, 200, ok);
        @(negedge clk);
        check("perr_wdf_end", perr, 1);
        send_cmd(3'b000, 28'h40, 200, ok);
        do_read(28'h40);
        wait_drain();
        check("wdf_end_data", last_rd, d);
        check("perr_sticky", perr, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
